time_bcd_keeper: RTL

Timekeeping stage of the wall-clock design: divides the system clock into a one-second tick and maintains hours, minutes and seconds as packed BCD. It also accepts raw set buttons. It sits directly upstream of the seven-segment display driver and supplies that driver's digit word, plus a colon-blink signal and a per-second strobe.

---
 rtl/time_bcd_keeper_if.sv | 25 ++
 rtl/time_bcd_keeper.sv | 90 +++++++++
 2 files changed

// File: rtl/time_bcd_keeper_if.sv
// Control inputs and BCD/display outputs of the wall-clock timekeeping stage.
// The master side drives run/clear/buttons/disp_sel and the keeper answers on the slave side.
interface time_bcd_keeper_if;
    logic        run;
    logic        clear;
    logic        btn_min;
    logic        btn_hour;
    logic        disp_sel;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic [7:0]  hour_bcd;
    logic [15:0] disp_word;
    logic        sec_pulse;
    logic        colon;

    modport master (
        output run, clear, btn_min, btn_hour, disp_sel,
        input  sec_bcd, min_bcd, hour_bcd, disp_word, sec_pulse, colon
    );

    modport slave (
        input  run, clear, btn_min, btn_hour, disp_sel,
        output sec_bcd, min_bcd, hour_bcd, disp_word, sec_pulse, colon
    );
endinterface

// File: rtl/time_bcd_keeper.sv
// One-second prescaler plus HH:MM:SS packed-BCD counters with synchronised set buttons.
// Feeds the seven-segment driver with a selectable digit word, a colon blink and a seconds strobe.
module time_bcd_keeper #(
    parameter int TICK_DIV = 65536
) (
    input  logic              clock,
    input  logic              reset,
    time_bcd_keeper_if.slave  bus
);
    localparam int              PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   HALF = PW'(TICK_DIV / 2);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next;
    logic [7:0]    sec_q, min_q, hour_q;
    logic [7:0]    sec_inc, min_inc, hour_inc;
    logic          sec_wrap, min_wrap;
    logic          tick, min_edge, hour_edge, min_carry, hour_carry;
    logic          sec_pulse_q, colon_q;
    logic [2:0]    min_sync, hour_sync;

    // BCD +1 over 00..59; the top bit flags the wrap back to 00.
    function automatic logic [8:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return 9'h100;
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        end
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A button edge already moves its field by one, so it swallows the carry from below.
    always_comb begin
        tick                = bus.run && (prescaler == LAST);
        {sec_wrap, sec_inc} = inc60(sec_q);
        {min_wrap, min_inc} = inc60(min_q);
        hour_inc            = inc24(hour_q);
        min_edge            = min_sync[1] & ~min_sync[2];
        hour_edge           = hour_sync[1] & ~hour_sync[2];
        min_carry           = tick & sec_wrap;
        hour_carry          = min_carry & min_wrap & ~min_edge;

        prescaler_next = prescaler;
        if (bus.clear)
            prescaler_next = '0;
        else if (bus.run)
            prescaler_next = (prescaler == LAST) ? '0 : prescaler + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler   <= '0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            sec_pulse_q <= 1'b0;
            colon_q     <= 1'b1;
            min_sync    <= 3'b000;
            hour_sync   <= 3'b000;
        end else begin
            prescaler   <= prescaler_next;
            colon_q     <= (prescaler_next < HALF);
            sec_pulse_q <= tick & ~bus.clear;
            min_sync    <= {min_sync[1:0], bus.btn_min};
            hour_sync   <= {hour_sync[1:0], bus.btn_hour};
            if (bus.clear) begin
                sec_q  <= 8'h00;
                min_q  <= 8'h00;
                hour_q <= 8'h00;
            end else begin
                if (tick)                     sec_q  <= sec_inc;
                if (min_edge || min_carry)    min_q  <= min_inc;
                if (hour_edge || hour_carry)  hour_q <= hour_inc;
            end
        end
    end

    assign bus.sec_bcd   = sec_q;
    assign bus.min_bcd   = min_q;
    assign bus.hour_bcd  = hour_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.colon     = colon_q;
    assign bus.disp_word = bus.disp_sel ? {min_q, sec_q} : {hour_q, min_q};
endmodule
